// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   state_t        : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   DEFAULT_WIDTH  : default operand/quotient/remainder width
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle for the restoring divider.
//   start, dividend, divisor               : request (master -> slave)
//   quotient, remainder, busy, done,
//   div_by_zero                            : result/status (slave -> master)
interface restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/sub_stage.sv
// Ripple-borrow subtractor: d = a - b - bin, bout = borrow out of the MSB.
//   a, b : WIDTH-bit operands
//   bin  : borrow in
//   d    : WIDTH-bit difference
//   bout : borrow out (1 when a < b + bin)
module sub_stage #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH:0] brw;

    assign brw[0] = bin;

    // One full-subtractor cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign d[i]       = a[i] ^ b[i] ^ brw[i];
        assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one shift-and-trial-subtract per clock.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of restoring_divider_if
//              start/dividend/divisor in; quotient/remainder/busy/done/
//              div_by_zero out. Results are registered and held until the
//              next completion; done pulses for the cycle the results land.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    restoring_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH:0]   r;        // partial remainder, extra MSB for the trial
    logic [WIDTH-1:0] q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d;        // latched divisor
    logic [CW-1:0]    count;

    logic             accept;
    logic             div_zero_req;
    logic             last_iter;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // A new request is taken whenever no iteration is in flight, which
    // includes the DONE cycle for back-to-back operation.
    assign accept       = bus.start && (state != RUN);
    assign div_zero_req = (bus.divisor == '0);
    assign last_iter    = (count == CW'(1));

    // {R,Q} << 1: the dividend MSB moves into the remainder LSB.
    assign r_shift = (r << 1) | (WIDTH + 1)'(q[WIDTH-1]);

    sub_stage #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a    (r_shift),
        .b    ({1'b0, d}),
        .bin  (1'b0),
        .d    (diff),
        .bout (borrow)
    );

    // Borrow means the trial failed: keep the shifted value (restore).
    assign r_step = borrow ? r_shift : diff;
    assign q_step = {q[WIDTH-2:0], ~borrow};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = div_zero_req ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_nxt = div_zero_req ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r               <= '0;
            q               <= '0;
            d               <= '0;
            count           <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            d     <= bus.divisor;
            r     <= '0;
            q     <= bus.dividend;
            count <= CW'(WIDTH);
            // Zero divisor skips the iterations and reports at once.
            if (div_zero_req) begin
                bus.quotient    <= '1;
                bus.remainder   <= bus.dividend;
                bus.div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            r     <= r_step;
            q     <= q_step;
            count <= count - CW'(1);
            // Remainder < divisor here, so the extra MSB is always 0.
            if (last_iter) begin
                bus.quotient    <= q_step;
                bus.remainder   <= r_step[WIDTH-1:0];
                bus.div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    restoring_divider_if #(.WIDTH(W)) dif ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a request; returns #1 after the accepting edge with start low.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = ~a;
        dif.divisor  = ~b;
    endtask

    // Called #1 after edge E+k0 (E = accepting edge). Waits for done, then
    // checks latency, busy behaviour and results.
    task automatic wait_result(input string name, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic edz, input int k0);
        int   k;
        logic busy_bad;
        k        = k0;
        busy_bad = 1'b0;
        while (!dif.done && k < 30) begin
            if (dif.busy !== (b != 0)) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        check({name, " done_seen"}, dif.done, 1);
        check({name, " latency"}, k, (b == 0) ? 0 : W);
        check({name, " busy_while_run"}, busy_bad, 0);
        check({name, " busy_at_done"}, dif.busy, 0);
        check({name, " quotient"}, dif.quotient, eq);
        check({name, " remainder"}, dif.remainder, er);
        check({name, " div_by_zero"}, dif.div_by_zero, edz);
    endtask

    task automatic end_pulse(input string name);
        @(posedge clk);
        #1;
        check({name, " done_single"}, dif.done, 0);
    endtask

    vec_t tbl [6];

    initial begin
        logic saw_done;
        logic [W-1:0] mq, mr;

        tbl[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, dz: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0};
        tbl[2] = '{a: 4'd2,  b: 4'd9, q: 4'd0,  r: 4'd2, dz: 1'b0};
        tbl[3] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0, dz: 1'b0};
        tbl[4] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, dz: 1'b1};
        tbl[5] = '{a: 4'd11, b: 4'd3, q: 4'd3,  r: 4'd2, dz: 1'b0};

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", dif.quotient, 0);
        check("reset remainder", dif.remainder, 0);
        check("reset busy", dif.busy, 0);
        check("reset done", dif.done, 0);
        check("reset div_by_zero", dif.div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            start_op(tbl[i].a, tbl[i].b);
            wait_result($sformatf("tbl%0d", i), tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 0);
            end_pulse($sformatf("tbl%0d", i));
        end

        // Start re-pulsed during RUN is ignored; start in DONE is accepted.
        start_op(4'd12, 4'd5);
        @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = 4'd9;
        dif.divisor  = 4'd2;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_result("ignore_run_start", 4'd5, 4'd2, 4'd2, 1'b0, 2);
        start_op(4'd9, 4'd2);
        check("b2b busy_after_accept", dif.busy, 1);
        check("b2b done_after_accept", dif.done, 0);
        wait_result("b2b", 4'd2, 4'd4, 4'd1, 1'b0, 0);
        end_pulse("b2b");

        // Reset in the second RUN cycle aborts.
        start_op(4'd11, 4'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort quotient", dif.quotient, 0);
        check("abort remainder", dif.remainder, 0);
        check("abort busy", dif.busy, 0);
        check("abort done", dif.done, 0);
        check("abort div_by_zero", dif.div_by_zero, 0);
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (dif.done || dif.busy) saw_done = 1'b1;
        end
        check("abort stays_idle", saw_done, 0);
        start_op(4'd11, 4'd3);
        wait_result("after_abort", 4'd3, 4'd3, 4'd2, 1'b0, 0);
        end_pulse("after_abort");

        // Exhaustive sweep against a reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                mq = (b == 0) ? 4'd15 : W'(a / b);
                mr = (b == 0) ? W'(a) : W'(a % b);
                start_op(W'(a), W'(b));
                wait_result($sformatf("sweep %0d/%0d", a, b), W'(b), mq, mr, b == 0, 0);
                end_pulse($sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
